// File: rtl/dla_hld_lsu_pkg.sv
// Shared types and helpers for the HLD LSU read-side data path.
package dla_hld_lsu_pkg;

  // Read assembler state. In HELD, the hold register contains the first
  // memory word of the next request.
  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  // True when a kernel word of kb bytes starting at byte `offset` runs past
  // the end of an mb-byte memory word. With offset < mb and kb <= mb, the sum
  // never needs more than one bit beyond the offset width.
  function automatic logic calc_span(input int unsigned offset,
                                     input int unsigned kb,
                                     input int unsigned mb);
    return (offset + kb) > mb;
  endfunction

endpackage

// File: rtl/dla_hld_lsu_data_aligner.sv
// Section-granular right shifter. Section `i_shift` of i_data lands at
// section 0 of o_data. The output is combinational (LATENCY=0) or delayed
// by LATENCY register stages.
module dla_hld_lsu_data_aligner #(
  parameter int I_DATA_WIDTH  = 1024,
  parameter int SECTION_WIDTH = 8,
  parameter int LATENCY       = 0,
  parameter int SHIFT_WIDTH   = $clog2(I_DATA_WIDTH / SECTION_WIDTH)
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [I_DATA_WIDTH-1:0] i_data,
  input  logic [SHIFT_WIDTH-1:0]  i_shift,
  output logic [I_DATA_WIDTH-1:0] o_data
);

  logic [I_DATA_WIDTH-1:0] shifted;

  // Shift toward bit 0 so that the selected section becomes the lowest one.
  assign shifted = i_data >> (32'(i_shift) * SECTION_WIDTH);

  if (LATENCY == 0) begin : g_comb
    logic unused_clk;
    assign unused_clk = clock ^ resetn;
    assign o_data     = shifted;
  end else begin : g_pipe
    logic [I_DATA_WIDTH-1:0] pipe [LATENCY];

    // Delay the shifted word through LATENCY register stages.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        // NOTE: every stage is reset so o_data is defined from the first
        // cycle; these are a few registers, not a RAM, so a reset is cheap.
        for (int s = 0; s < LATENCY; s++) begin
          pipe[s] <= '0;
        end
      end else begin
        // NOTE: non-blocking assignments let each stage read the previous
        // stage's old value, giving a true shift register.
        pipe[0] <= shifted;
        for (int s = 1; s < LATENCY; s++) begin
          pipe[s] <= pipe[s-1];
        end
      end
    end

    assign o_data = pipe[LATENCY-1];
  end

endmodule

// File: rtl/dla_hld_lsu_read_data_assembler.sv
// Read-side data assembler: turns memory-width read words plus a per-request
// (offset, keep) metadata stream into one aligned kernel word per request,
// stitching two memory words when a request straddles them and letting
// coalesced requests share one returned word.
module dla_hld_lsu_read_data_assembler
  import dla_hld_lsu_pkg::*;
#(
  parameter int MEM_DATA_WIDTH    = 512,
  parameter int KERNEL_DATA_WIDTH = 32,
  parameter int OFFSET_WIDTH      = (MEM_DATA_WIDTH / 8 > 1) ? $clog2(MEM_DATA_WIDTH / 8) : 1
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         i_meta_valid,
  input  logic [OFFSET_WIDTH-1:0]      i_meta_offset,
  input  logic                         i_meta_keep,
  output logic                         o_meta_stall,
  input  logic                         i_mem_valid,
  input  logic [MEM_DATA_WIDTH-1:0]    i_mem_data,
  output logic                         o_mem_stall,
  output logic                         o_valid,
  output logic [KERNEL_DATA_WIDTH-1:0] o_data,
  input  logic                         i_stall
);

  localparam int KB           = KERNEL_DATA_WIDTH / 8;
  localparam int MB           = MEM_DATA_WIDTH / 8;
  localparam int WINDOW_WIDTH = 2 * MEM_DATA_WIDTH;
  localparam int SHIFT_WIDTH  = OFFSET_WIDTH + 1;

  state_t                             state;
  logic [MEM_DATA_WIDTH-1:0]          hold_reg;

  logic                               out_ready;
  logic                               span;
  logic                               fire;
  logic                               mem_take;
  logic [MEM_DATA_WIDTH-1:0]          window_lo;
  logic [WINDOW_WIDTH-1:0]            window;
  logic [WINDOW_WIDTH-1:0]            aligned;
  logic [KERNEL_DATA_WIDTH-1:0]       aligned_data;
  logic [WINDOW_WIDTH-KERNEL_DATA_WIDTH-1:0] aligned_unused;

  // The output register can take a new word when empty or being drained.
  assign out_ready = !o_valid || !i_stall;
  assign span      = calc_span(32'(i_meta_offset), KB, MB);

  // In EMPTY only non-span requests fire, and they read straight from the
  // incoming word; in HELD the held word is the low half of the window.
  assign window_lo = (state == HELD) ? hold_reg : i_mem_data;
  assign window    = {i_mem_data, window_lo};

  dla_hld_lsu_data_aligner #(
    .I_DATA_WIDTH  (WINDOW_WIDTH),
    .SECTION_WIDTH (8),
    .LATENCY       (0),
    .SHIFT_WIDTH   (SHIFT_WIDTH)
  ) u_aligner (
    .clock   (clock),
    .resetn  (resetn),
    .i_data  (window),
    .i_shift ({1'b0, i_meta_offset}),
    .o_data  (aligned)
  );

  assign {aligned_unused, aligned_data} = aligned;

  // Decide whether a request fires and whether a memory word is consumed.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    fire     = 1'b0;
    mem_take = 1'b0;
    unique case (state)
      EMPTY: begin
        if (i_meta_valid && i_mem_valid && out_ready) begin
          // A straddling request only captures its first word here and
          // fires next cycle from HELD.
          mem_take = 1'b1;
          fire     = !span;
        end
      end
      HELD: begin
        if (i_meta_valid && out_ready) begin
          if (!span) begin
            fire = 1'b1;
          end else if (i_mem_valid) begin
            fire     = 1'b1;
            mem_take = 1'b1;
          end
        end
      end
      default: begin
        fire     = 1'b0;
        mem_take = 1'b0;
      end
    endcase
  end

  assign o_meta_stall = !fire;
  assign o_mem_stall  = !mem_take;

  // FSM, hold register and output register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= EMPTY;
      hold_reg <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
    end else begin
      if (fire) begin
        o_valid <= 1'b1;
        o_data  <= aligned_data;
      end else if (out_ready) begin
        o_valid <= 1'b0;
      end

      unique case (state)
        EMPTY: begin
          // Keep the word when a straddling request needs it next cycle or
          // when the following request starts in this same word.
          if (mem_take && (span || i_meta_keep)) begin
            hold_reg <= i_mem_data;
            state    <= HELD;
          end
        end
        HELD: begin
          if (fire) begin
            if (!i_meta_keep) begin
              state <= EMPTY;
            end else if (span) begin
              hold_reg <= i_mem_data;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_dla_hld_lsu_read_data_assembler.sv
// Directed bench for the read data assembler (64-bit memory, 32-bit kernel).
// A stream-level model predicts every kernel word from the metadata and
// memory streams; a compare process checks each output transfer against it.
module tb_dla_hld_lsu_read_data_assembler;

  localparam int MW = 64;
  localparam int KW = 32;
  localparam int OW = 3;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          i_meta_valid;
  logic [OW-1:0] i_meta_offset;
  logic          i_meta_keep;
  logic          o_meta_stall;
  logic          i_mem_valid;
  logic [MW-1:0] i_mem_data;
  logic          o_mem_stall;
  logic          o_valid;
  logic [KW-1:0] o_data;
  logic          i_stall;

  always #5 clock = ~clock;

  dla_hld_lsu_read_data_assembler #(
    .MEM_DATA_WIDTH    (MW),
    .KERNEL_DATA_WIDTH (KW),
    .OFFSET_WIDTH      (OW)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .i_meta_valid  (i_meta_valid),
    .i_meta_offset (i_meta_offset),
    .i_meta_keep   (i_meta_keep),
    .o_meta_stall  (o_meta_stall),
    .i_mem_valid   (i_mem_valid),
    .i_mem_data    (i_mem_data),
    .o_mem_stall   (o_mem_stall),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .i_stall       (i_stall)
  );

  typedef struct packed {
    logic [OW-1:0] off;
    logic          keep;
  } req_t;

  req_t          meta_q[$];
  logic [MW-1:0] mem_q[$];
  logic [KW-1:0] exp_q[$];
  logic [MW-1:0] m_mem[$];
  bit            m_have;
  logic [MW-1:0] m_first;

  int checks = 0;
  int errors = 0;
  int mem_taken = 0;
  int base;
  bit last_meta_stall;
  bit last_mem_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory words go to both the DUT stream and the model's word list.
  function automatic void add_mem(input logic [MW-1:0] w);
    mem_q.push_back(w);
    m_mem.push_back(w);
  endfunction

  // Model: a request takes its first word from the held word or the next
  // returned word, a second word if it straddles, and yields the KW bits
  // starting at byte `off` of the two-word window.
  function automatic void add_req(input int off, input bit keep);
    logic [2*MW-1:0] win;
    logic [MW-1:0]   second;
    bit              sp;
    req_t            r;
    sp = (off + KW / 8) > (MW / 8);
    if (!m_have) m_first = m_mem.pop_front();
    second = '0;
    if (sp) second = m_mem.pop_front();
    win = {second, m_first};
    exp_q.push_back(KW'(win >> (off * 8)));
    m_have = keep;
    if (keep && sp) m_first = second;
    r.off  = OW'(off);
    r.keep = keep;
    meta_q.push_back(r);
  endfunction

  task automatic drive();
    i_meta_valid  = (meta_q.size() != 0);
    i_meta_offset = (meta_q.size() != 0) ? meta_q[0].off : '0;
    i_meta_keep   = (meta_q.size() != 0) ? meta_q[0].keep : 1'b0;
    i_mem_valid   = (mem_q.size() != 0);
    i_mem_data    = (mem_q.size() != 0) ? mem_q[0] : '0;
  endtask

  // One clock: present stream heads, sample handshakes mid-cycle, pop what
  // the DUT accepted, and return #1 after the rising edge.
  task automatic step();
    bit tm, tk;
    drive();
    @(negedge clock);
    last_meta_stall = o_meta_stall;
    last_mem_stall  = o_mem_stall;
    tm = i_meta_valid && !o_meta_stall;
    tk = i_mem_valid && !o_mem_stall;
    @(posedge clock);
    #1;
    if (tm) meta_q.delete(0);
    if (tk) begin
      mem_q.delete(0);
      mem_taken++;
    end
    drive();
  endtask

  // Every output transfer must match the next predicted kernel word.
  always @(negedge clock) begin
    logic [KW-1:0] e;
    if (resetn && o_valid && !i_stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got 0x%0h expected no output", o_data);
      end else begin
        e = exp_q.pop_front();
        check("out_stream", 64'(o_data), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_stall = 1'b0;
    drive();
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_meta_stall", 64'(o_meta_stall), 64'd1);
    check("rst_mem_stall", 64'(o_mem_stall), 64'd1);
    resetn = 1'b1;

    // Aligned read.
    add_mem(64'h1122334455667788);
    add_req(0, 1'b0);
    step();
    check("s1_valid", 64'(o_valid), 64'd1);
    check("s1_data", 64'(o_data), 64'h55667788);
    check("s1_meta_stall", 64'(last_meta_stall), 64'd0);
    check("s1_mem_stall", 64'(last_mem_stall), 64'd0);
    step();
    check("s1_idle", 64'(o_valid), 64'd0);

    // Straddling read from EMPTY.
    add_mem(64'h8877665544332211);
    add_mem(64'hFFEEDDCCBBAA9988);
    add_req(6, 1'b0);
    step();
    check("s2_first_meta_stall", 64'(last_meta_stall), 64'd1);
    check("s2_first_mem_stall", 64'(last_mem_stall), 64'd0);
    check("s2_not_yet_valid", 64'(o_valid), 64'd0);
    step();
    check("s2_valid", 64'(o_valid), 64'd1);
    check("s2_data", 64'(o_data), 64'h99888877);

    // Coalesced reuse of one memory word.
    base = mem_taken;
    add_mem(64'h1122334455667788);
    add_req(0, 1'b1);
    add_req(4, 1'b0);
    step();
    check("s3_data0", 64'(o_data), 64'h55667788);
    step();
    check("s3_data1", 64'(o_data), 64'h11223344);
    check("s3_reuse_mem_stall", 64'(last_mem_stall), 64'd1);
    check("s3_reuse_meta_stall", 64'(last_meta_stall), 64'd0);
    check("s3_mem_beats", 64'(mem_taken - base), 64'd1);

    // Backpressure with a pending output and new inputs valid.
    add_mem(64'h0102030405060708);
    add_req(0, 1'b0);
    step();
    check("bp_first", 64'(o_data), 64'h05060708);
    i_stall = 1'b1;
    add_mem(64'hA1A2A3A4A5A6A7A8);
    add_req(4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", 64'(o_valid), 64'd1);
      check("bp_hold_data", 64'(o_data), 64'h05060708);
      check("bp_meta_stall", 64'(last_meta_stall), 64'd1);
      check("bp_mem_stall", 64'(last_mem_stall), 64'd1);
    end
    i_stall = 1'b0;
    step();
    check("bp_next_data", 64'(o_data), 64'hA1A2A3A4);
    step();
    check("bp_drained", 64'(o_valid), 64'd0);
    check("bp_no_loss", 64'(meta_q.size() + mem_q.size()), 64'd0);

    // Reset while HELD discards the held word and the pending output.
    add_mem(64'h1122334455667788);
    add_req(0, 1'b1);
    step();
    check("rh_data", 64'(o_data), 64'h55667788);
    resetn = 1'b0;
    #1;
    check("rh_valid_cleared", 64'(o_valid), 64'd0);
    check("rh_data_cleared", 64'(o_data), 64'd0);
    meta_q.delete();
    mem_q.delete();
    exp_q.delete();
    m_mem.delete();
    m_have = 1'b0;
    drive();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    add_mem(64'hCAFEBABEDEADBEEF);
    step();
    check("rh_mem_without_meta", 64'(last_mem_stall), 64'd1);
    check("rh_idle", 64'(o_valid), 64'd0);
    add_req(4, 1'b0);
    step();
    check("rh_fresh_mem", 64'(last_mem_stall), 64'd0);
    check("rh_fresh_data", 64'(o_data), 64'hCAFEBABE);

    // Streaming: eight aligned requests on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      add_mem({32'hF0F00000 | 32'(i), 32'hA5A50000 | 32'(i)});
      add_req(0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      check("st_valid", 64'(o_valid), 64'd1);
      check("st_meta_stall", 64'(last_meta_stall), 64'd0);
    end
    check("st_last_data", 64'(o_data), 64'hA5A50007);
    step();
    step();
    check("final_idle", 64'(o_valid), 64'd0);
    check("final_exp_drained", 64'(exp_q.size()), 64'd0);
    check("final_streams_drained", 64'(meta_q.size() + mem_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dla_hld_lsu_read_data_assembler.md
# dla_hld_lsu_read_data_assembler

Read-side data assembler for the HLD LSU. It sits between the memory read-data return path and the kernel downstream interface. It takes memory-width read words plus a per-request metadata stream (byte offset and keep flag) and produces one aligned kernel-width word per request. When an unaligned kernel access straddles two memory words, it stitches the two words together. It also lets several coalesced requests reuse one returned memory word.

## Interface
- MEM_DATA_WIDTH, 512: memory word width in bits; multiple of 8; MEM_DATA_WIDTH/8 is a power of 2.
- KERNEL_DATA_WIDTH, 32: kernel word width in bits; multiple of 8; must be ≤ MEM_DATA_WIDTH.
- OFFSET_WIDTH, $clog2(MEM_DATA_WIDTH/8): byte-offset width; minimum 1.

Ports:
- clock  in  1  clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- i_meta_valid  in  1  request metadata valid.
- i_meta_offset  in  OFFSET_WIDTH  byte offset of kernel word within its first memory word.
- i_meta_keep  in  1  the last memory word touched by this request is also the first word of the next request.
- o_meta_stall  out  1  metadata not consumed this cycle.
- i_mem_valid  in  1  memory read word valid.
- i_mem_data  in  MEM_DATA_WIDTH  memory read word.
- o_mem_stall  out  1  memory word not consumed this cycle.
- o_valid  out  1  kernel word valid.
- o_data  out  KERNEL_DATA_WIDTH  aligned kernel word, little-endian byte order.
- i_stall  in  1  downstream backpressure.

## Operation
- Definitions:
  - KB = KERNEL_DATA_WIDTH/8.
  - MB = MEM_DATA_WIDTH/8.
  - span = (offset + KB > MB), computed internally at OFFSET_WIDTH+1 bits.
- out_ready = !o_valid || !i_stall. A request "fires" when it is consumed and loads the output register.
- State EMPTY means no held word. State HELD means hold_reg contains the first memory word of the next request.
- EMPTY, meta valid, mem valid, out_ready:
  - !span: fire. o_data = bytes [offset, offset+KB) of i_mem_data. Consume meta and mem. Next state is HELD with hold_reg = i_mem_data if keep, else EMPTY.
  - span: no fire. Consume mem only and set hold_reg = i_mem_data. Next state is HELD.
- HELD, meta valid, out_ready:
  - !span: fire from hold_reg. Consume meta; do not consume mem. Stay HELD if keep, else go to EMPTY.
  - span: requires mem valid. Fire from the window {i_mem_data, hold_reg} at byte offset. Consume meta and mem. If keep, stay HELD with hold_reg = i_mem_data; else go to EMPTY.
- Stall outputs:
  - o_meta_stall = !(request fires this cycle).
  - o_mem_stall = !(mem word consumed this cycle).
- The span-from-EMPTY capture also requires out_ready. This keeps control simple.
- The shift window is 2×MEM_DATA_WIDTH. Byte `offset` of the window lands at o_data byte 0.

## Timing
- Reset values: o_valid = 0, o_data = 0, state = EMPTY, hold_reg = 0. Reset asserts asynchronously; deassertion is synchronized externally.
- Latency is 1 cycle from the fire edge to o_valid.
- Throughput:
  - one word per cycle for non-span requests, and for span requests arriving in HELD;
  - 2 cycles for a span request arriving in EMPTY.
- While o_valid && i_stall, o_data and o_valid hold stable and nothing is consumed.
- o_meta_stall and o_mem_stall are combinational from i_stall, i_meta_valid, i_meta_offset, i_mem_valid and state.
- Simultaneous fire and drain: the output register reloads in the same cycle.
- Reset mid-operation discards the held word and any pending output. The upstream must reissue both streams consistently after reset.
- Memory words arriving with no metadata are stalled, not dropped.

## Structure
- Shared package dla_hld_lsu_pkg holds:
  - the state enum (EMPTY, HELD);
  - a function computing span from offset, KB and MB.
- One sub-module: dla_hld_lsu_data_aligner, instantiated with LATENCY=0, SECTION_WIDTH=8 and I_DATA_WIDTH=2×MEM_DATA_WIDTH.
  - The shift direction is chosen so that window byte `offset` maps to byte 0.
  - The low KERNEL_DATA_WIDTH bits are taken as the result.
- The FSM, hold register and output register live in the top module.

## Test plan
Configuration for all scenarios: MEM_DATA_WIDTH=64, KERNEL_DATA_WIDTH=32.
- Aligned read: offset=0, keep=0, mem=0x1122334455667788 → o_data=0x55667788 on the next cycle; state returns to EMPTY.
- Straddling read from EMPTY: offset=6, keep=0, words 0x8877665544332211 then 0xFFEEDDCCBBAA9988 on consecutive cycles → o_data=0x99888877, o_valid 2 cycles after the first word. The first-cycle o_meta_stall is 1.
- Coalesced reuse: two requests at offsets 0 (keep=1) and 4 (keep=0), one mem word 0x1122334455667788 → 0x55667788 then 0x11223344 on consecutive cycles. Exactly one mem beat is consumed.
- Backpressure: i_stall=1 for 3 cycles with a pending output and new inputs valid → o_data stable, o_meta_stall=o_mem_stall=1. After release, no loss and no duplication.
- Reset in HELD: after the keep request of the coalesced-reuse scenario, pulse resetn → o_valid=0 immediately and state=EMPTY. The next request must consume a fresh mem word.
- Streaming: 8 aligned non-keep requests with matching mem words, i_stall=0 → 8 outputs on 8 consecutive cycles.
